// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS M stage: one access per handshake, fixed LATENCY, left-aligned loads.
// Optional alignment checking and the misalign port are enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done
`ifdef DMEM_ALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

    stateT               stateQ, stateD;
    logic [3:0]          cntQ, cntD;
    logic [ADDR_W+1:0]   capAddrQ;
    logic [3:0]          capBeQ;
    logic [31:0]         capWdataQ;
    logic [31:0]         rdataQ;
    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W+1:0]   opAddr;
    logic [ADDR_W-1:0]   opIdx;
    logic [3:0]          opBe;
    logic [31:0]         opWdata;
    logic [31:0]         oldWord, newWord, loadWord;
    logic                wrLegal, isLoad, misCalc, doOp, memWe;
    logic                unusedAddr;

    assign unusedAddr = ^addr[31:ADDR_W+2];

    // With LATENCY=1 the access completes on the accepting edge, so use the live inputs.
    assign opAddr  = (stateQ == StIdle) ? addr[ADDR_W+1:0] : capAddrQ;
    assign opBe    = (stateQ == StIdle) ? be : capBeQ;
    assign opWdata = (stateQ == StIdle) ? wdata : capWdataQ;
    assign opIdx   = opAddr[ADDR_W+1:2];
    assign isLoad  = (opBe == 4'b0000);

    assign doOp = ((stateQ == StIdle) && req && (LATENCY == 1)) ||
                  ((stateQ == StWait) && (cntQ == 4'd1));

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        case (stateQ)
            StIdle: begin
                if (req) begin
                    cntD   = 4'(LATENCY - 1);
                    stateD = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                // The counter reaches zero on the completing edge.
                cntD = cntQ - 4'd1;
                if (cntQ == 4'd1) begin
                    stateD = StResp;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        oldWord = mem[opIdx];
        newWord = oldWord;
        wrLegal = 1'b1;
        case (opBe)
            4'b1000: newWord[31:24] = opWdata[7:0];
            4'b0100: newWord[23:16] = opWdata[7:0];
            4'b0010: newWord[15:8]  = opWdata[7:0];
            4'b0001: newWord[7:0]   = opWdata[7:0];
            4'b1100: newWord[31:16] = opWdata[15:0];
            4'b0011: newWord[15:0]  = opWdata[15:0];
            4'b1111: newWord        = opWdata;
            default: wrLegal        = 1'b0;
        endcase
        loadWord = oldWord << {opAddr[1:0], 3'b000};
    end

`ifdef DMEM_ALIGN_CHK_EN
    always_comb begin
        case (opBe)
            4'b0000: misCalc = opAddr[0];
            4'b1000: misCalc = (opAddr[1:0] != 2'd0);
            4'b0100: misCalc = (opAddr[1:0] != 2'd1);
            4'b0010: misCalc = (opAddr[1:0] != 2'd2);
            4'b0001: misCalc = (opAddr[1:0] != 2'd3);
            4'b1100: misCalc = (opAddr[1:0] != 2'd0);
            4'b0011: misCalc = (opAddr[1:0] != 2'd2);
            4'b1111: misCalc = (opAddr[1:0] != 2'd0);
            default: misCalc = 1'b1;
        endcase
    end

    logic misalignQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalignQ <= 1'b0;
        end else begin
            misalignQ <= doOp & misCalc;
        end
    end

    assign misalign = misalignQ;
`else
    assign misCalc = 1'b0;
`endif

    assign memWe = doOp & wrLegal & ~isLoad & ~misCalc & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= 4'd0;
            rdataQ <= 32'd0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (doOp && isLoad) begin
                rdataQ <= misCalc ? 32'd0 : loadWord;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((stateQ == StIdle) && req) begin
            capAddrQ  <= addr[ADDR_W+1:0];
            capBeQ    <= be;
            capWdataQ <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[opIdx] <= newWord;
        end
    end

    assign rdata = rdataQ;
    assign done  = (stateQ == StResp);
    assign stall = req & (stateQ != StResp) & ~rst;

endmodule
